frame_downscaler: RTL and testbench

Streaming, parametrised box-filter downscaler for the digit-recognition input path. It takes a raster pixel stream, one pixel per accepted beat, and averages every non-overlapping K×K block (K = 2^SCALE_LOG2) into one output pixel. It keeps one partial-sum accumulator per output column, so whole frames are reduced with no frame buffer. Valid/ready handshakes on both sides let the block sit between the capture front end and the neural-network input memory.

---
 rtl/frame_downscaler.sv | 144 ++++++++++++++
 tb/tb_frame_downscaler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_downscaler.sv
// -----------------------------------------------------------------------------
// frame_downscaler
//
// Streaming box-filter downscaler. The raster input stream is reduced by
// averaging every non-overlapping KxK block (K = 2**SCALE_LOG2) into one output
// pixel. One partial-sum accumulator per output column is kept, so a whole
// frame is reduced without buffering the frame.
//
// Parameters:
//   RESOLUTION  bits per pixel (input and output)
//   IMG_WIDTH   input pixels per line, multiple of K
//   IMG_HEIGHT  input lines per frame, multiple of K
//   SCALE_LOG2  log2 of the block edge K (must be >= 1)
//   ROUND       0 = truncate, 1 = round half up
//
// Ports:
//   clk        single clock, all state on the rising edge
//   reset      asynchronous, active-low
//   in_pixel   input pixel value
//   in_valid   in_pixel is valid
//   in_sof     current beat is the first pixel of a frame
//   in_ready   block can accept a beat this cycle
//   out_pixel  averaged pixel
//   out_valid  out_pixel is valid
//   out_ready  sink accepts out_pixel
//   out_eof    high with the last output pixel of a frame
//   frame_err  one-cycle pulse when in_sof arrives away from position (0,0)
// -----------------------------------------------------------------------------
module frame_downscaler #(
   parameter int RESOLUTION = 8,
   parameter int IMG_WIDTH  = 160,
   parameter int IMG_HEIGHT = 160,
   parameter int SCALE_LOG2 = 1,
   parameter int ROUND      = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [RESOLUTION-1:0] in_pixel,
   input  logic                  in_valid,
   input  logic                  in_sof,
   output logic                  in_ready,
   output logic [RESOLUTION-1:0] out_pixel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_eof,
   output logic                  frame_err
);

   localparam int K    = 1 << SCALE_LOG2;
   localparam int NBLK = IMG_WIDTH / K;
   localparam int ACCW = RESOLUTION + 2 * SCALE_LOG2;
   localparam int COLW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROWW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int BXW  = (NBLK > 1) ? $clog2(NBLK) : 1;

   localparam logic [COLW-1:0] COL_LAST = COLW'(IMG_WIDTH - 1);
   localparam logic [ROWW-1:0] ROW_LAST = ROWW'(IMG_HEIGHT - 1);
   localparam logic [COLW-1:0] CX_MASK  = COLW'(K - 1);
   localparam logic [ROWW-1:0] RY_MASK  = ROWW'(K - 1);
   localparam logic [ACCW-1:0] RND_BIAS = (ROUND != 0) ? ACCW'(K * K / 2) : '0;

   logic [COLW-1:0] col;
   logic [ROWW-1:0] row;
   logic [COLW-1:0] eff_col;
   logic [ROWW-1:0] eff_row;
   logic [ACCW-1:0] acc [NBLK];

   logic            accept;
   logic            at_origin;
   logic            restart;
   logic            blk_first;
   logic            blk_last;
   logic            frame_last;
   logic [BXW-1:0]  bx;
   logic [ACCW-1:0] acc_base;
   logic [ACCW-1:0] acc_next;
   logic [ACCW-1:0] sum;

   // A completing beat must never overwrite an unconsumed result, so the
   // input side simply stalls whenever the output register is full and the
   // sink is not taking it this cycle.
   assign in_ready = !out_valid || out_ready;

   // Beat decode. An in_sof away from the origin restarts the frame, so the
   // offending beat is treated as position (0,0) everywhere below. The sum
   // of the KxK block fits in ACCW bits, and the rounding bias cannot carry
   // past it, so no saturation is needed.
   always_comb begin
      accept     = in_valid && in_ready;
      at_origin  = (col == '0) && (row == '0);
      restart    = in_sof && !at_origin;
      eff_col    = restart ? '0 : col;
      eff_row    = restart ? '0 : row;
      bx         = BXW'(eff_col >> SCALE_LOG2);
      blk_first  = ((eff_col & CX_MASK) == '0) && ((eff_row & RY_MASK) == '0);
      blk_last   = ((eff_col & CX_MASK) == CX_MASK) && ((eff_row & RY_MASK) == RY_MASK);
      frame_last = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
      acc_base   = blk_first ? '0 : acc[bx];
      acc_next   = acc_base + ACCW'(in_pixel);
      sum        = acc_next + RND_BIAS;
   end

   // Raster position counters, frame error pulse and the single-entry output
   // register. A new result loads even when the old one is being handed off
   // in the same cycle; otherwise a handoff empties the register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col       <= '0;
         row       <= '0;
         out_pixel <= '0;
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= accept && restart;
         if (accept) begin
            if (eff_col == COL_LAST) begin
               col <= '0;
               row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
               col <= eff_col + 1'b1;
               row <= eff_row;
            end
         end
         if (accept && blk_last) begin
            out_valid <= 1'b1;
            out_pixel <= RESOLUTION'(sum >> (2 * SCALE_LOG2));
            out_eof   <= frame_last;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
         end
      end
   end

   // Per-column partial sums. No reset: the first pixel of every block
   // overwrites its entry, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (accept) begin
         acc[bx] <= acc_next;
      end
   end

endmodule

// File: tb/tb_frame_downscaler.sv
// -----------------------------------------------------------------------------
// tb_frame_downscaler
//
// Drives three downscaler instances from one pixel stream:
//   dutA  4x4 frames, K=2, truncate, out_ready controlled by the bench
//   dutB  4x4 frames, K=2, round half up, always ready
//   dutC  8x8 frames, K=4, round half up, always ready
// dutB/dutC see a beat only when dutA accepts it, so all three consume the
// same sequence. A reference model stores each frame as an image and averages
// whole blocks when they complete; one compare process checks all outputs
// every cycle, and directed phases pin the model with literal results.
// -----------------------------------------------------------------------------
module tb_frame_downscaler;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] inPixel;
   logic       inValid;
   logic       inSof;
   logic       outReadyA;
   logic       inValidBC;

   logic       inReadyA, outValidA, outEofA, frameErrA;
   logic [7:0] outPixelA;
   logic       inReadyB, outValidB, outEofB, frameErrB;
   logic [7:0] outPixelB;
   logic       inReadyC, outValidC, outEofC, frameErrC;
   logic [7:0] outPixelC;

   int  checks = 0;
   int  errors = 0;
   bit  randReady = 1'b0;

   int  beatIdx [3];
   bit  expValid [3];
   int  expPix [3];
   bit  expEof [3];
   bit  expErr [3];
   int  img [3][64];
   int  errPulses [3];
   int  logA [$];
   int  logB [$];
   int  logC [$];

   int  frm [16] = '{10, 20, 30, 40, 11, 21, 31, 41,
                     255, 255, 255, 255, 255, 255, 255, 255};

   always #5 clk = ~clk;

   assign inValidBC = inValid && inReadyA;

   frame_downscaler #(.RESOLUTION(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SCALE_LOG2(1), .ROUND(0)) dutA (
      .clk(clk), .reset(reset), .in_pixel(inPixel), .in_valid(inValid), .in_sof(inSof),
      .in_ready(inReadyA), .out_pixel(outPixelA), .out_valid(outValidA), .out_ready(outReadyA),
      .out_eof(outEofA), .frame_err(frameErrA));

   frame_downscaler #(.RESOLUTION(8), .IMG_WIDTH(4), .IMG_HEIGHT(4), .SCALE_LOG2(1), .ROUND(1)) dutB (
      .clk(clk), .reset(reset), .in_pixel(inPixel), .in_valid(inValidBC), .in_sof(inSof),
      .in_ready(inReadyB), .out_pixel(outPixelB), .out_valid(outValidB), .out_ready(1'b1),
      .out_eof(outEofB), .frame_err(frameErrB));

   frame_downscaler #(.RESOLUTION(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .SCALE_LOG2(2), .ROUND(1)) dutC (
      .clk(clk), .reset(reset), .in_pixel(inPixel), .in_valid(inValidBC), .in_sof(inSof),
      .in_ready(inReadyC), .out_pixel(outPixelC), .out_valid(outValidC), .out_ready(1'b1),
      .out_eof(outEofC), .frame_err(frameErrC));

   // Single comparison primitive: every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model for one instance: compares the current outputs with the
   // expected output register, then advances the model with this cycle's beat.
   task automatic modelCycle(input int id, input int w, input int h, input int s, input int rnd,
                             input logic vIn, input logic rIn, input logic [7:0] pix,
                             input logic v, input logic e, input logic fe, input logic rdy);
      int n, r, c, k, sum;
      bit load, hs, acc;
      if (!reset) begin
         checkOutput($sformatf("dut%0d_reset_valid", id), v, 0);
         checkOutput($sformatf("dut%0d_reset_pixel", id), pix, 0);
         checkOutput($sformatf("dut%0d_reset_eof", id), e, 0);
         checkOutput($sformatf("dut%0d_reset_err", id), fe, 0);
         beatIdx[id]  = 0;
         expValid[id] = 1'b0;
         expErr[id]   = 1'b0;
         return;
      end
      checkOutput($sformatf("dut%0d_out_valid", id), v, expValid[id]);
      if (expValid[id]) begin
         checkOutput($sformatf("dut%0d_out_pixel", id), pix, expPix[id]);
         checkOutput($sformatf("dut%0d_out_eof", id), e, expEof[id]);
      end
      checkOutput($sformatf("dut%0d_frame_err", id), fe, expErr[id]);
      checkOutput($sformatf("dut%0d_in_ready", id), rIn, !expValid[id] || rdy);
      if (v && rdy) begin
         case (id)
            0: logA.push_back(int'(pix) + (e ? 256 : 0));
            1: logB.push_back(int'(pix) + (e ? 256 : 0));
            default: logC.push_back(int'(pix) + (e ? 256 : 0));
         endcase
      end
      if (fe) errPulses[id]++;
      hs   = expValid[id] && rdy;
      acc  = vIn && (!expValid[id] || rdy);
      load = 1'b0;
      expErr[id] = 1'b0;
      if (acc) begin
         n = beatIdx[id];
         if (inSof) begin
            if (n != 0) expErr[id] = 1'b1;
            n = 0;
         end
         img[id][n] = int'(inPixel);
         r = n / w;
         c = n % w;
         k = 1 << s;
         if ((c % k == k - 1) && (r % k == k - 1)) begin
            sum = 0;
            for (int rr = 0; rr < k; rr++)
               for (int cc = 0; cc < k; cc++)
                  sum += img[id][(r - rr) * w + (c - cc)];
            if (rnd != 0) sum += k * k / 2;
            expPix[id] = sum >> (2 * s);
            expEof[id] = (n == w * h - 1);
            load = 1'b1;
         end
         beatIdx[id] = (n + 1) % (w * h);
      end
      if (load) expValid[id] = 1'b1;
      else if (hs) expValid[id] = 1'b0;
   endtask

   always @(negedge clk) begin
      modelCycle(0, 4, 4, 1, 0, inValid,   inReadyA, outPixelA, outValidA, outEofA, frameErrA, outReadyA);
      modelCycle(1, 4, 4, 1, 1, inValidBC, inReadyB, outPixelB, outValidB, outEofB, frameErrB, 1'b1);
      modelCycle(2, 8, 8, 2, 1, inValidBC, inReadyC, outPixelC, outValidC, outEofC, frameErrC, 1'b1);
   end

   // Entry 'back' positions from the end of an instance's output log
   // (pixel + 256 when eof was set), or -1 when the log is too short.
   function automatic int lastLog(input int id, input int back);
      int sz;
      sz = (id == 0) ? logA.size() : (id == 1) ? logB.size() : logC.size();
      if (back >= sz) return -1;
      if (id == 0) return logA[sz - 1 - back];
      if (id == 1) return logB[sz - 1 - back];
      return logC[sz - 1 - back];
   endfunction

   // Present one beat and hold it until dutA accepts it (bounded wait).
   task automatic applyStimulus(input logic [7:0] p, input logic s);
      int  waitCnt;
      bit  done;
      waitCnt = 0;
      done    = 1'b0;
      inPixel = p;
      inSof   = s;
      inValid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (inReadyA) done = 1'b1;
         else waitCnt++;
         @(posedge clk);
         #1;
         if (randReady) outReadyA = ($urandom_range(0, 3) != 0);
         if (!done && waitCnt > 200) begin
            checkOutput("accept_timeout", 0, 1);
            done = 1'b1;
         end
      end
      inValid = 1'b0;
      inSof   = 1'b0;
   endtask

   task automatic idle(input int n);
      inValid = 1'b0;
      inSof   = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (randReady) outReadyA = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic sendFrame();
      for (int i = 0; i < 16; i++) applyStimulus(frm[i][7:0], i == 0);
   endtask

   task automatic checkTruncateA(input string name);
      checkOutput({name, "_0"}, lastLog(0, 3), 15);
      checkOutput({name, "_1"}, lastLog(0, 2), 35);
      checkOutput({name, "_2"}, lastLog(0, 1), 255);
      checkOutput({name, "_3"}, lastLog(0, 0), 255 + 256);
   endtask

   initial begin
      int errBefore, cBefore;
      reset     = 1'b0;
      inPixel   = '0;
      inValid   = 1'b0;
      inSof     = 1'b0;
      outReadyA = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state_valid", outValidA, 0);
      checkOutput("reset_state_pixel", outPixelA, 0);
      checkOutput("reset_state_err", frameErrA, 0);
      reset = 1'b1;
      idle(2);

      // Truncate and round results on the reference 4x4 frame.
      sendFrame();
      idle(3);
      checkTruncateA("truncate");
      checkOutput("round_0", lastLog(1, 3), 16);
      checkOutput("round_1", lastLog(1, 2), 36);
      checkOutput("round_2", lastLog(1, 1), 255);
      checkOutput("round_3", lastLog(1, 0), 255 + 256);

      // Backpressure: stall the sink after the first result.
      outReadyA = 1'b0;
      for (int i = 0; i < 6; i++) applyStimulus(frm[i][7:0], i == 0);
      inPixel = frm[6][7:0];
      inValid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("bp_in_ready", inReadyA, 0);
      checkOutput("bp_out_valid", outValidA, 1);
      checkOutput("bp_out_pixel", outPixelA, 15);
      @(posedge clk);
      #1;
      outReadyA = 1'b1;
      for (int i = 6; i < 16; i++) applyStimulus(frm[i][7:0], 1'b0);
      idle(3);
      checkTruncateA("backpressure");

      // Mid-frame SOF on input pixel 6.
      errBefore = errPulses[0];
      for (int i = 0; i < 6; i++) applyStimulus(frm[i][7:0], i == 0);
      sendFrame();
      idle(3);
      checkOutput("midsof_err_pulses", errPulses[0] - errBefore, 1);
      checkTruncateA("midsof");

      // Reset mid-frame with a result pending.
      outReadyA = 1'b0;
      for (int i = 0; i < 6; i++) applyStimulus(frm[i][7:0], i == 0);
      checkOutput("rstmid_pending_valid", outValidA, 1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rstmid_valid", outValidA, 0);
      checkOutput("rstmid_pixel", outPixelA, 0);
      checkOutput("rstmid_eof", outEofA, 0);
      repeat (2) @(posedge clk);
      #1;
      reset     = 1'b1;
      outReadyA = 1'b1;
      idle(1);
      sendFrame();
      idle(3);
      checkTruncateA("rstmid_after");

      // Maximum value through the K=4 rounding instance.
      cBefore = logC.size();
      for (int i = 0; i < 64; i++) applyStimulus(8'd255, i == 0);
      idle(3);
      checkOutput("max_count", logC.size() - cBefore, 4);
      checkOutput("max_0", lastLog(2, 3), 255);
      checkOutput("max_1", lastLog(2, 2), 255);
      checkOutput("max_2", lastLog(2, 1), 255);
      checkOutput("max_3", lastLog(2, 0), 255 + 256);

      // Randomised traffic: gaps, sink stalls, occasional stray SOF.
      randReady = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 24) == 0);
      end
      randReady = 1'b0;
      outReadyA = 1'b1;
      idle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
